// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Brief    : Fetch program-counter generator. Presents a valid/ready fetch
//            request, steps on accepted fetches, and takes prioritised
//            redirects, buffering them across stalls. Supports halt/wake.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h4000_0000),
    parameter int              STEP      = 4,
    parameter int              NUM_REDIR = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [NUM_REDIR-1:0]      redir_valid_i,
    input  logic [NUM_REDIR*XLEN-1:0] redir_target_i,
    input  logic                      stall_i,
    input  logic                      halt_i,
    input  logic                      fetch_ready_i,
    output logic                      fetch_valid_o,
    output logic [XLEN-1:0]           fetch_pc_o,
    output logic                      misalign_o
);

    localparam logic [XLEN-1:0] c_LOW_MASK = XLEN'(STEP - 1);
    localparam logic [XLEN-1:0] c_STEP     = XLEN'(STEP);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pend_tgt;
    logic            r_pend;
    logic            r_valid;
    logic            r_misalign;

    logic [XLEN-1:0] w_tgt_arr [NUM_REDIR];
    logic            w_any_redir;
    logic [XLEN-1:0] w_sel_tgt;
    logic [XLEN-1:0] w_load_src;
    logic [XLEN-1:0] w_load_pc;
    logic            w_load_mis;
    logic            w_fire;

    generate
        for (genvar k = 0; k < NUM_REDIR; k++) begin : g_unpack
            assign w_tgt_arr[k] = redir_target_i[k*XLEN +: XLEN];
        end
    endgenerate

    // Scan from the highest index down so the lowest requesting channel wins.
    always_comb begin
        w_sel_tgt = '0;
        for (int k = NUM_REDIR - 1; k >= 0; k--) begin
            if (redir_valid_i[k]) begin
                w_sel_tgt = w_tgt_arr[k];
            end
        end
    end

    assign w_any_redir = |redir_valid_i;
    assign w_load_src  = w_any_redir ? w_sel_tgt : r_pend_tgt;
    assign w_load_pc   = w_load_src & ~c_LOW_MASK;
    assign w_load_mis  = |(w_load_src & c_LOW_MASK);
    assign w_fire      = r_valid & fetch_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_VEC;
            r_pend     <= 1'b0;
            r_pend_tgt <= '0;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                S_BOOT: begin
                    r_state <= S_RUN;
                    r_valid <= 1'b1;
                end
                S_RUN, S_HALT: begin
                    if (stall_i) begin
                        // Raw target is kept so alignment is judged when it is applied.
                        if (w_any_redir) begin
                            r_pend     <= 1'b1;
                            r_pend_tgt <= w_sel_tgt;
                        end
                        if (r_state == S_RUN && halt_i && !w_any_redir && !r_pend) begin
                            r_state <= S_HALT;
                            r_valid <= 1'b0;
                        end
                    end else if (w_any_redir || r_pend) begin
                        r_pc       <= w_load_pc;
                        r_misalign <= w_load_mis;
                        r_pend     <= 1'b0;
                        r_state    <= S_RUN;
                        r_valid    <= 1'b1;
                    end else if (r_state == S_RUN) begin
                        if (w_fire) begin
                            r_pc <= r_pc + c_STEP;
                        end
                        if (halt_i) begin
                            r_state <= S_HALT;
                            r_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_valid_o = r_valid;
    assign fetch_pc_o    = r_pc;
    assign misalign_o    = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Brief    : Directed self-checking bench for pc_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    logic        clk;
    logic        rst_n;
    logic [1:0]  redir_valid;
    logic [63:0] redir_target;
    logic        stall;
    logic        halt;
    logic        ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        misalign;

    int tests  = 0;
    int failed = 0;

    pc_gen #(
        .XLEN      (32),
        .RESET_VEC (32'h4000_0000),
        .STEP      (4),
        .NUM_REDIR (2)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .redir_valid_i  (redir_valid),
        .redir_target_i (redir_target),
        .stall_i        (stall),
        .halt_i         (halt),
        .fetch_ready_i  (ready),
        .fetch_valid_o  (fetch_valid),
        .fetch_pc_o     (fetch_pc),
        .misalign_o     (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] pc, input logic m);
        check({tag, ".valid"}, {31'd0, fetch_valid}, {31'd0, v});
        check({tag, ".pc"}, fetch_pc, pc);
        check({tag, ".misalign"}, {31'd0, misalign}, {31'd0, m});
    endtask

    initial begin
        rst_n        = 1'b0;
        redir_valid  = 2'b00;
        redir_target = '0;
        stall        = 1'b0;
        halt         = 1'b0;
        ready        = 1'b1;

        // Reset state and boot sequence
        @(negedge clk);
        @(negedge clk);
        check_out("reset", 1'b0, 32'h4000_0000, 1'b0);
        rst_n = 1'b1;
        #1;
        check_out("boot", 1'b0, 32'h4000_0000, 1'b0);
        @(negedge clk);
        check_out("run0", 1'b1, 32'h4000_0000, 1'b0);
        tick(); check_out("run1", 1'b1, 32'h4000_0004, 1'b0);
        tick(); check_out("run2", 1'b1, 32'h4000_0008, 1'b0);
        tick(); check("run3", fetch_pc, 32'h4000_000C);
        tick(); check("run4", fetch_pc, 32'h4000_0010);

        // Backpressure holds the PC
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); check_out("bp_hold", 1'b1, 32'h4000_0010, 1'b0);
        end
        ready = 1'b1;
        tick(); check("bp_release", fetch_pc, 32'h4000_0014);

        // Priority: both channels, channel 0 wins
        ready        = 1'b0;
        redir_valid  = 2'b11;
        redir_target = {32'h0000_0200, 32'h0000_0100};
        tick(); check_out("prio", 1'b1, 32'h0000_0100, 1'b0);

        // Misaligned target on channel 1
        redir_valid  = 2'b10;
        redir_target = {32'h0000_0203, 32'h0000_0000};
        tick(); check_out("misal_load", 1'b1, 32'h0000_0200, 1'b1);
        redir_valid = 2'b00;
        tick(); check_out("misal_clear", 1'b1, 32'h0000_0200, 1'b0);

        // Stall buffers redirects; the newest wins and outranks a fire
        stall = 1'b1;
        ready = 1'b1;
        tick(); check("stall_c1", fetch_pc, 32'h0000_0200);
        redir_valid  = 2'b10;
        redir_target = {32'h0000_0300, 32'h0000_0000};
        tick(); check("stall_c2", fetch_pc, 32'h0000_0200);
        redir_valid = 2'b00;
        tick(); check("stall_c3", fetch_pc, 32'h0000_0200);
        redir_valid  = 2'b10;
        redir_target = {32'h0000_0400, 32'h0000_0000};
        tick(); check("stall_c4", fetch_pc, 32'h0000_0200);
        redir_valid = 2'b00;
        stall       = 1'b0;
        tick(); check_out("stall_apply", 1'b1, 32'h0000_0400, 1'b0);

        // Halt at 0x500 and wake on redirect
        ready        = 1'b0;
        redir_valid  = 2'b01;
        redir_target = {32'h0000_0000, 32'h0000_0500};
        tick(); check("halt_setup", fetch_pc, 32'h0000_0500);
        redir_valid = 2'b00;
        halt        = 1'b1;
        tick(); check_out("halt_enter", 1'b0, 32'h0000_0500, 1'b0);
        tick(); check_out("halt_stay", 1'b0, 32'h0000_0500, 1'b0);
        redir_valid  = 2'b01;
        redir_target = {32'h0000_0000, 32'h0000_0800};
        tick(); check_out("halt_wake", 1'b1, 32'h0000_0800, 1'b0);
        redir_valid = 2'b00;
        halt        = 1'b0;

        // Wrap at the top of the address space
        redir_valid  = 2'b01;
        redir_target = {32'h0000_0000, 32'hFFFF_FFFC};
        tick(); check("wrap_setup", fetch_pc, 32'hFFFF_FFFC);
        redir_valid = 2'b00;
        ready       = 1'b1;
        tick(); check_out("wrap", 1'b1, 32'h0000_0000, 1'b0);

        // Asynchronous reset while a redirect is pending
        ready        = 1'b0;
        stall        = 1'b1;
        redir_valid  = 2'b10;
        redir_target = {32'h0000_0900, 32'h0000_0000};
        tick(); check("pend_setup", fetch_pc, 32'h0000_0000);
        redir_valid = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 32'h4000_0000, 1'b0);
        stall = 1'b0;
        ready = 1'b1;
        #1;
        rst_n = 1'b1;
        #1;
        check("reboot_boot", {31'd0, fetch_valid}, 32'd0);
        @(negedge clk);
        check_out("reboot_run0", 1'b1, 32'h4000_0000, 1'b0);
        tick(); check_out("reboot_run1", 1'b1, 32'h4000_0004, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch program-counter generator that replaces the plain load-enabled PC register in the fetch stage. It holds the current fetch address and presents it to instruction memory over a valid/ready handshake. It self-increments by a fixed step when a fetch is accepted and takes prioritised redirects from several sources. Redirects that arrive during a pipeline stall are buffered, and the block supports a halt/wake mode.

## Interface
- XLEN, 32, address width in bits
- RESET_VEC, 32'h4000_0000, PC value loaded on reset
- STEP, 4, byte increment per accepted fetch; power of two, >= 2
- NUM_REDIR, 2, number of redirect channels; channel 0 has highest priority
- clk_i  input  1  clock; all state updates on rising edge
- rst_n_i  input  1  reset; asynchronous, active-low
- redir_valid_i  input  NUM_REDIR  per-channel redirect request
- redir_target_i  input  NUM_REDIR*XLEN  per-channel target; channel k occupies bits [k*XLEN +: XLEN]
- stall_i  input  1  pipeline stall; freezes the PC and buffers redirects
- halt_i  input  1  request to enter HALT
- fetch_ready_i  input  1  instruction memory accepts the current request
- fetch_valid_o  output  1  fetch request valid
- fetch_pc_o  output  XLEN  current fetch address (registered)
- misalign_o  output  1  one-cycle pulse: the applied redirect target was not STEP-aligned

## Operation
- States:
  - BOOT: entered on reset; lasts exactly one cycle, then RUN.
  - RUN: fetch_valid_o=1.
  - HALT: fetch_valid_o=0; PC held.
- Reset (rst_n_i low, asynchronous) sets the following; pend_q/pend_tgt_q are internal.
  - pc_q=RESET_VEC, state=BOOT, fetch_valid_o=0, misalign_o=0
  - pend_q=0, pend_tgt_q=0
- Redirect selection: sel = lowest index k with redir_valid_i[k]=1; tgt = that channel's target.
- Next-PC priority in RUN, highest first:
  1. stall_i=1: pc_q holds. If any redir_valid_i, pend_q<=1 and pend_tgt_q<=tgt; a newer redirect overwrites an older pending one.
  2. A live redirect (any redir_valid_i): pc_q<=tgt and pend_q<=0. The live redirect supersedes any pending one.
  3. pend_q=1: pc_q<=pend_tgt_q and pend_q<=0.
  4. Fire (fetch_valid_o & fetch_ready_i): pc_q<=pc_q+STEP, modulo 2^XLEN.
  5. Otherwise pc_q holds.
- Redirect aborts the outstanding request. fetch_pc_o may change while fetch_ready_i=0 only because of a redirect, and instruction memory treats that as a kill of the old request.
- Alignment: a loaded target has its low log2(STEP) bits forced to 0. If any of those bits were nonzero, misalign_o=1 for the cycle after the load.
- halt_i=1 in RUN with no redirect and no pending redirect: go to HALT next cycle. A fire in that same cycle still advances the PC.
- HALT:
  - A live redirect loads pc_q, applying the alignment rule, and returns to RUN.
  - halt_i is ignored while in HALT.
  - stall_i buffers redirects as in RUN; a pending redirect wakes the block on the first cycle with stall_i=0.
- BOOT: redirects and halt_i are ignored and pc_q stays RESET_VEC.
- Wrap: pc_q = 2^XLEN - STEP with a fire gives 0. There is no wrap flag.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset release at edge E0: fetch_valid_o=1 after edge E1, with fetch_pc_o=RESET_VEC.
- Fire at edge N: fetch_pc_o=pc+STEP after N.
- Redirect sampled at edge N with stall_i=0: fetch_pc_o=tgt after N, so latency is 1 cycle.
- Redirect buffered during a stall: applied at the first edge where stall_i=0.
- Reset asserted mid-operation: all state clears immediately, including a pending redirect and HALT.

## Test plan
- Reset release with fetch_ready_i=1 constantly: fetch_valid_o low for the BOOT cycle, then fetch_pc_o = 0x4000_0000, 0x4000_0004, 0x4000_0008 on consecutive cycles.
- fetch_ready_i=0 for 3 cycles at pc 0x4000_0010: fetch_pc_o stays 0x4000_0010 and fetch_valid_o stays 1; one cycle after ready rises, fetch_pc_o = 0x4000_0014.
- Redirect priority and alignment:
  - Channels 0 (target 0x100) and 1 (target 0x200) in the same cycle: fetch_pc_o=0x100 next cycle.
  - Channel 1 alone with target 0x203: fetch_pc_o=0x200 and misalign_o pulses once.
- Stall with two redirects: stall_i high 4 cycles; channel 1 fires 0x300, then channel 1 fires 0x400. The PC holds throughout; on the first unstalled cycle fetch_pc_o=0x400.
- Halt and wake: halt_i in RUN at pc 0x500 with ready=0 gives fetch_valid_o=0 and the PC held. A channel-0 redirect to 0x800 then gives RUN with fetch_pc_o=0x800 on the next cycle.
- Wrap and asynchronous reset:
  - pc=0xFFFF_FFFC with a fire gives pc=0x0000_0000.
  - rst_n_i pulsed low mid-cycle while a pending redirect is set: fetch_valid_o drops immediately, pend_q clears, and the boot sequence repeats from 0x4000_0000.
